// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring monitor.
package ring_pkg;

  // Helpers operate on a fixed wide vector; callers zero-extend and pass the real width.
  localparam int unsigned MaxN = 64;

  typedef enum logic [1:0] {
    HUNT,
    LOCKED,
    FAULT
  } state_e;

  function automatic logic onehot(input logic [MaxN-1:0] x);
    return (x != '0) && ((x & (x - MaxN'(1))) == '0);
  endfunction

  // Rotate the low n bits left by one; bits at and above n are cleared.
  function automatic logic [MaxN-1:0] rotl(input logic [MaxN-1:0] x, input int unsigned n);
    logic [MaxN-1:0] mask;
    mask = (n >= MaxN) ? '1 : ((MaxN'(1) << n) - MaxN'(1));
    return ((x << 1) | ((x >> (n - 1)) & MaxN'(1))) & mask;
  endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Ring sample in, status/position/revolution/fault reporting out.
interface ring_monitor_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned REV_W = 8
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     ring_i;
  logic             err_clr_i;
  logic [IW-1:0]    idx_o;
  logic             valid_o;
  logic             locked_o;
  logic [REV_W-1:0] rev_o;
  logic             err_o;
  logic             resync_o;

  modport master (
    output ring_i, err_clr_i,
    input  idx_o, valid_o, locked_o, rev_o, err_o, resync_o
  );

  modport slave (
    input  ring_i, err_clr_i,
    output idx_o, valid_o, locked_o, rev_o, err_o, resync_o
  );
endinterface

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder; valid_o flags exactly one bit set.
module onehot_enc
  import ring_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  assign valid_o = onehot(MaxN'(vec_i));

  // OR of set-bit positions; only meaningful when valid_o is high.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = idx_o | IW'(i);
    end
  end

endmodule

// File: rtl/ring_monitor.sv
// Receive-side checker for a one-hot ring counter: lock tracking, revolution
// counting, sticky fault flag and a one-cycle resync request.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned REV_W    = 8
) (
  input  logic          clk_i,
  input  logic          clr_i,
  ring_monitor_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(LOCK_CNT + 1);

  logic [N-1:0]     ring, prev_q;
  state_e           state_q;
  logic [CW-1:0]    lock_cnt_q;
  logic [IW-1:0]    idx_q, enc_idx;
  logic             valid_q, enc_valid;
  logic             locked_q, err_q, resync_q;
  logic [REV_W-1:0] rev_q;
  logic             good, wrap;

  assign ring = bus.ring_i;

  onehot_enc #(.N(N)) u_enc (
    .vec_i   (ring),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign good = onehot(MaxN'(ring)) && onehot(MaxN'(prev_q)) &&
                ((ring == prev_q) || (ring == N'(rotl(MaxN'(prev_q), N))));
  assign wrap = good && prev_q[N-1] && ring[0] && (ring != prev_q);

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      prev_q     <= '0;
      state_q    <= HUNT;
      lock_cnt_q <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      resync_q   <= 1'b0;
      rev_q      <= '0;
    end else begin
      prev_q   <= ring;
      resync_q <= 1'b0;
      valid_q  <= enc_valid;
      if (enc_valid) idx_q <= enc_idx;
      if (bus.err_clr_i) err_q <= 1'b0;

      unique case (state_q)
        HUNT: begin
          if (!good) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == CW'(LOCK_CNT - 1)) begin
            state_q    <= LOCKED;
            locked_q   <= 1'b1;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          // A fault seen on the same edge as err_clr_i overrides the clear above.
          if (!good) begin
            state_q  <= FAULT;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            resync_q <= 1'b1;
          end else if (wrap) begin
            rev_q <= rev_q + REV_W'(1);
          end
        end
        FAULT: begin
          state_q    <= HUNT;
          lock_cnt_q <= '0;
        end
        default: begin
          state_q    <= HUNT;
          locked_q   <= 1'b0;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.idx_o    = idx_q;
  assign bus.valid_o  = valid_q;
  assign bus.locked_o = locked_q;
  assign bus.rev_o    = rev_q;
  assign bus.err_o    = err_q;
  assign bus.resync_o = resync_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed self-checking bench for ring_monitor (N=4, LOCK_CNT=2, REV_W=8).
module tb_ring_monitor;

  logic clk = 1'b0;
  logic clr;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ring_monitor_if #(.N(4), .REV_W(8)) bus ();

  ring_monitor #(.N(4), .LOCK_CNT(2), .REV_W(8)) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] idx, input logic valid,
                           input logic locked, input logic [31:0] rev, input logic err,
                           input logic resync);
    check({tag, ".idx"}, 32'(bus.idx_o), idx);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(valid));
    check({tag, ".locked"}, 32'(bus.locked_o), 32'(locked));
    check({tag, ".rev"}, 32'(bus.rev_o), rev);
    check({tag, ".err"}, 32'(bus.err_o), 32'(err));
    check({tag, ".resync"}, 32'(bus.resync_o), 32'(resync));
  endtask

  initial begin
    clr           = 1'b1;
    bus.ring_i    = 4'b0001;
    bus.err_clr_i = 1'b0;
    #2;
    check_all("reset_hold", 0, 0, 0, 0, 0, 0);
    tick();
    check_all("reset_edge", 0, 0, 0, 0, 0, 0);
    clr = 1'b0;

    // Edge 1 fills prev, edges 2-3 count good samples.
    tick();
    check_all("lock_e1", 0, 1, 0, 0, 0, 0);
    tick();
    check("lock_e2.locked", 32'(bus.locked_o), 0);
    tick();
    check_all("lock_e3", 0, 1, 1, 0, 0, 0);

    // Three full revolutions.
    for (int k = 1; k <= 12; k++) begin
      bus.ring_i = 4'(1 << (k % 4));
      tick();
      check("rot.idx", 32'(bus.idx_o), 32'(k % 4));
      check("rot.rev", 32'(bus.rev_o), 32'(k / 4));
      check("rot.locked", 32'(bus.locked_o), 1);
      check("rot.err", 32'(bus.err_o), 0);
    end

    // Non-one-hot injection from 0001.
    bus.ring_i = 4'b0110;
    tick();
    check_all("inj", 0, 0, 0, 3, 1, 1);
    bus.ring_i = 4'b0001;
    tick();
    check_all("inj_fault", 0, 1, 0, 3, 1, 0);
    tick();
    check("inj_hunt1.locked", 32'(bus.locked_o), 0);
    tick();
    check_all("inj_relock", 0, 1, 1, 3, 1, 0);

    // Clear alone.
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("clr_only.err", 32'(bus.err_o), 0);
    check("clr_only.locked", 32'(bus.locked_o), 1);

    // Illegal skip 0001 -> 0100.
    bus.ring_i = 4'b0100;
    tick();
    check_all("skip", 2, 1, 0, 3, 1, 1);
    tick();
    check("skip_fault.resync", 32'(bus.resync_o), 0);
    tick();
    tick();
    check("skip_relock.locked", 32'(bus.locked_o), 1);

    // Clear and new fault on the same edge: fault wins.
    bus.ring_i    = 4'b0000;
    bus.err_clr_i = 1'b1;
    tick();
    check_all("race", 2, 0, 0, 3, 1, 1);
    tick();
    check("race_next.err", 32'(bus.err_o), 0);
    bus.err_clr_i = 1'b0;

    // Relock, step once, then reset between edges.
    bus.ring_i = 4'b0001;
    tick();
    tick();
    tick();
    check("pre_clr.locked", 32'(bus.locked_o), 1);
    bus.ring_i = 4'b0010;
    tick();
    check("pre_clr.idx", 32'(bus.idx_o), 1);
    #2;
    clr = 1'b1;
    #1;
    check_all("async_clr", 0, 0, 0, 0, 0, 0);
    tick();
    check_all("async_clr_edge", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Receive-side checker for the one-hot ring counter bus. Samples the N-bit ring state every clock, validates that it is one-hot and that each change is a single legal rotation step, and reports the binary position, a lock status, and a revolution count. On a fault it raises a sticky error and emits a one-cycle resync request, which the ring's preset/clear network consumes to reload its seed.

## Interface
- N, 4, ring width in flip-flops (N ≥ 2)
- LOCK_CNT, 2, consecutive good samples required to declare lock (≥ 1)
- REV_W, 8, width of the revolution counter
- clk_i  input  1  clock; all state updates on posedge
- clr_i  input  1  reset, asynchronous, active-high; also the ring's clear name in this codebase
- ring_i  input  N  ring counter state, same clock domain
- err_clr_i  input  1  clears sticky err_o
- idx_o  output  $clog2(N)  binary index of the set bit in the last sample
- valid_o  output  1  last sample was exactly one-hot
- locked_o  output  1  FSM is in LOCKED
- rev_o  output  REV_W  completed revolutions while locked
- err_o  output  1  sticky fault flag
- resync_o  output  1  one-cycle pulse requesting a ring preset

## Operation
- Internal prev register, N bits, holds the previous ring_i sample. It loads ring_i on every edge.
- onehot(x): exactly one bit of x is set.
- rotl(x) = {x[N-2:0], x[N-1]}. This is the only legal step direction.
- good = onehot(ring_i) && onehot(prev) && (ring_i == prev || ring_i == rotl(prev)).
- wrap = good && prev[N-1] && ring_i[0] && ring_i != prev.
- FSM states:
  - HUNT (reset state):
    - good: lock_cnt += 1.
    - !good: lock_cnt <= 0.
    - When the increment reaches LOCK_CNT: go to LOCKED and clear lock_cnt.
  - LOCKED:
    - !good: go to FAULT, set err_o, assert resync_o for the transition cycle.
    - wrap: rev_o += 1, modulo 2^REV_W.
  - FAULT: unconditionally go to HUNT on the next edge, with lock_cnt = 0.
- idx_o and valid_o are registered from ring_i each edge, in every state.
  - When ring_i is not one-hot, idx_o holds its previous value and valid_o = 0.
- rev_o is cleared only by clr_i. It holds its value through FAULT and HUNT.
- err_o stays set until err_clr_i is high at an edge.
  - A new fault detected on the same edge wins: err_o stays 1.
- While clr_i is high: all outputs = 0, prev = 0, lock_cnt = 0, state = HUNT, regardless of the clock.

## Timing
- All outputs are registered, with 1-cycle latency from ring_i to idx_o/valid_o.
- Lock latency: after reset release with a steady legal ring, locked_o rises on the (LOCK_CNT+1)-th edge. The first edge only fills prev.
- Fault detection: err_o, resync_o, and locked_o=0 all appear on the edge that samples the bad ring_i.
- resync_o is high for exactly one cycle per LOCKED→FAULT transition. It is never asserted in HUNT.
- Earliest relock after a fault: FAULT (1 cycle) + LOCK_CNT good edges.
- Reset is asynchronous on assertion. Release is sampled at the next edge; the integrator synchronises deassertion externally.

## Structure
- Package ring_pkg contains:
  - state enum {HUNT, LOCKED, FAULT};
  - onehot and rotl functions, parameterised through N.
- Sub-module onehot_enc: N-bit one-hot to binary encoder with a valid flag. It is combinational and instantiated once on ring_i.
- Top level holds the FSM, prev, lock_cnt (width $clog2(LOCK_CNT+1)), rev_o and err_o registers.

## Test plan
- Reset hold, N=4, LOCK_CNT=2, ring_i=0001 constant after clr_i falls:
  - locked_o=1 after edge 3;
  - idx_o=0, valid_o=1;
  - rev_o=0, err_o=0.
- Locked, ring stepping 0001→0010→0100→1000→0001 every cycle for 3 revolutions:
  - rev_o=3, idx_o cycles 0,1,2,3;
  - no err_o.
- Locked, inject ring_i=0110:
  - err_o=1, resync_o one-cycle pulse, locked_o=0, valid_o=0;
  - after ring restored to 0001 and held, relock after 1+2 edges;
  - rev_o unchanged.
- Locked, illegal skip 0001→0100 (both one-hot):
  - fault as above, valid_o=1, idx_o=2.
- err_clr_i and a new fault on the same edge: err_o remains 1. err_clr_i alone on a later edge: err_o=0.
- clr_i asserted mid-revolution between edges: all outputs go to 0 immediately, without waiting for a clock edge.
